// File: rtl/collision_checker.sv
// Cursor-vs-obstacle collision detection, life accounting,
// post-hit invulnerability and game-over tracking.
module collision_checker #(
    parameter int CURSOR_W        = 12,
    parameter int CURSOR_H        = 12,
    parameter int FRAME_END_V     = 767,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_on,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        collision,
    output logic [2:0]  lives_left,
    output logic        invulnerable,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COOLDOWN,
        GAME_OVER
    } state_t;

    localparam logic [11:0] TICK_V     = 12'(FRAME_END_V);
    localparam logic [12:0] W_M1       = 13'(CURSOR_W - 1);
    localparam logic [12:0] H_M1       = 13'(CURSOR_H - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [7:0]  COOL_INIT  = 8'(COOLDOWN_FRAMES);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] mx;
    logic [11:0] my;
    logic        hit_flag;
    logic        frame_valid;
    logic [7:0]  cooldown_cnt;

    logic        collision_nxt;
    logic [2:0]  lives_nxt;
    logic        frame_valid_nxt;
    logic [7:0]  cooldown_nxt;

    logic        frame_tick;
    logic        pixel_present;
    logic        pixel_hit;
    logic        frame_hit;
    logic [12:0] x_hi;
    logic [12:0] y_hi;

    // The box edges are 13 bits wide so a cursor near 4095 never wraps to 0.
    assign frame_tick    = (hcount_in == 12'd0) && (vcount_in == TICK_V);
    assign x_hi          = {1'b0, mx} + W_M1;
    assign y_hi          = {1'b0, my} + H_M1;
    assign pixel_present = (|obstacle_x) || (|obstacle_y);
    assign pixel_hit     = pixel_present
                         && (obstacle_x >= mx)
                         && ({1'b0, obstacle_x} <= x_hi)
                         && (obstacle_y >= my)
                         && ({1'b0, obstacle_y} <= y_hi);
    assign frame_hit     = hit_flag | pixel_hit;

    // Cursor shadow: sampled once per frame so hit tests see a fixed box.
    always_ff @(posedge clk) begin
        if (rst) begin
            mx <= 12'd0;
            my <= 12'd0;
        end else if (frame_tick) begin
            mx <= mouse_xpos;
            my <= mouse_ypos;
        end
    end

    // Per-frame hit accumulator; cleared at each tick and while invulnerable.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_flag <= 1'b0;
        end else if (frame_tick || (state == COOLDOWN)) begin
            hit_flag <= 1'b0;
        end else if (pixel_hit) begin
            hit_flag <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the scoring registers.
    always_comb begin
        state_nxt       = state;
        collision_nxt   = 1'b0;
        lives_nxt       = lives_left;
        frame_valid_nxt = frame_valid;
        cooldown_nxt    = cooldown_cnt;
        if (!game_on) begin
            state_nxt       = IDLE;
            lives_nxt       = LIVES_INIT;
            frame_valid_nxt = 1'b0;
            cooldown_nxt    = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    lives_nxt       = LIVES_INIT;
                    frame_valid_nxt = 1'b0;
                    state_nxt       = ARMED;
                end
                ARMED: begin
                    if (frame_tick) begin
                        if (!frame_valid) begin
                            frame_valid_nxt = 1'b1;
                        end else if (frame_hit) begin
                            collision_nxt = 1'b1;
                            if (lives_left <= 3'd1) begin
                                lives_nxt = 3'd0;
                                state_nxt = GAME_OVER;
                            end else begin
                                lives_nxt    = lives_left - 3'd1;
                                cooldown_nxt = COOL_INIT;
                                state_nxt    = COOLDOWN;
                            end
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cooldown_cnt <= 8'd1) begin
                            cooldown_nxt = 8'd0;
                            state_nxt    = ARMED;
                        end else begin
                            cooldown_nxt = cooldown_cnt - 8'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    lives_nxt = 3'd0;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Scoring registers updated from the decisions above.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision    <= 1'b0;
            lives_left   <= LIVES_INIT;
            frame_valid  <= 1'b0;
            cooldown_cnt <= 8'd0;
        end else begin
            collision    <= collision_nxt;
            lives_left   <= lives_nxt;
            frame_valid  <= frame_valid_nxt;
            cooldown_cnt <= cooldown_nxt;
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        invulnerable = (state == COOLDOWN);
        game_over    = (state == GAME_OVER);
    end

endmodule
